// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: NOP encoding, fetch FSM states, reset PC.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface ifetch_if;
  import riscv_pkg::*;

  logic            ImemReq;
  logic [XLEN-1:0] ImemAddr;
  logic            ImemValid;
  logic [XLEN-1:0] ImemRData;

  modport master (output ImemReq, ImemAddr, input ImemValid, ImemRData);
  modport slave  (input ImemReq, ImemAddr, output ImemValid, ImemRData);

endinterface

// File: rtl/ifetch_if_id.sv
// IF/ID pipeline register: flush beats load, neither asserted means hold.
module if_id
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [XLEN-1:0] InstrD,
  output logic            ValidD
);

  // Decode-side register update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PCD      <= '0;
      PCPlus4D <= '0;
      InstrD   <= NOP;
      ValidD   <= 1'b0;
    end else if (flush) begin
      InstrD   <= NOP;
      ValidD   <= 1'b0;
    end else if (load) begin
      PCD      <= load_pc;
      PCPlus4D <= load_pc + XLEN'(4);
      InstrD   <= load_instr;
      ValidD   <= 1'b1;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: single-outstanding request sequencer, PCF, hold buffer.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN (adds MisalignF, parks fetch on
// a misaligned redirect until the next aligned one).
module ifetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  ifetch_if.master        imem,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [XLEN-1:0] InstrD,
  output logic            ValidD
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic            MisalignF
`endif
);

  fetch_state_e    state;
  logic [XLEN-1:0] pcf;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] hold_instr;
  logic            drop_pending;
  logic            misalign;

  logic [XLEN-1:0] target_c;
  logic            bad_target_c;
  logic            accept_c;
  logic            load_c;
  logic [XLEN-1:0] load_pc_c;
  logic [XLEN-1:0] load_instr_c;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign target_c     = PCTargetE;
  assign bad_target_c = PCSrcE && (PCTargetE[1:0] != 2'b00);
  assign MisalignF    = misalign;
`else
  logic unused_target_lsbs;
  assign target_c           = {PCTargetE[XLEN-1:2], 2'b00};
  assign bad_target_c       = 1'b0;
  assign unused_target_lsbs = ^PCTargetE[1:0];
`endif

  // A response counts only while awaiting one, never in the request-pulse cycle
  assign accept_c = (state == FETCH) && !imem.ImemReq && imem.ImemValid;

  // IF/ID load source: live response or hold buffer
  always_comb begin
    load_c       = 1'b0;
    load_pc_c    = pcf;
    load_instr_c = imem.ImemRData;
    if (!StallD) begin
      if (state == HOLD) begin
        load_c       = 1'b1;
        load_pc_c    = hold_pc;
        load_instr_c = hold_instr;
      end else if (accept_c && !drop_pending) begin
        load_c = 1'b1;
      end
    end
  end

  // Fetch sequencer: requests, PCF, drop tracking, hold buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pcf           <= RESET_PC;
      hold_pc       <= '0;
      hold_instr    <= NOP;
      drop_pending  <= 1'b0;
      misalign      <= 1'b0;
      imem.ImemReq  <= 1'b0;
      imem.ImemAddr <= RESET_PC;
    end else begin
      imem.ImemReq <= 1'b0;
      if (PCSrcE) begin
        pcf      <= target_c;
        misalign <= bad_target_c;
        if ((state == FETCH) && !accept_c) begin
          drop_pending <= 1'b1;
          state        <= FETCH;
        end else if (bad_target_c) begin
          drop_pending <= 1'b0;
          state        <= IDLE;
        end else begin
          drop_pending  <= 1'b0;
          imem.ImemReq  <= 1'b1;
          imem.ImemAddr <= target_c;
          state         <= FETCH;
        end
      end else begin
        case (state)
          IDLE: begin
            if (!misalign) begin
              imem.ImemReq  <= 1'b1;
              imem.ImemAddr <= pcf;
              state         <= FETCH;
            end
          end
          FETCH: begin
            if (accept_c) begin
              if (drop_pending) begin
                drop_pending <= 1'b0;
                if (misalign) begin
                  state <= IDLE;
                end else begin
                  imem.ImemReq  <= 1'b1;
                  imem.ImemAddr <= pcf;
                end
              end else begin
                pcf <= pcf + XLEN'(4);
                if (StallD) begin
                  hold_pc    <= pcf;
                  hold_instr <= imem.ImemRData;
                  state      <= HOLD;
                end else begin
                  imem.ImemReq  <= 1'b1;
                  imem.ImemAddr <= pcf + XLEN'(4);
                end
              end
            end
          end
          HOLD: begin
            if (!StallD) begin
              imem.ImemReq  <= 1'b1;
              imem.ImemAddr <= pcf;
              state         <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  if_id u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load       (load_c),
    .flush      (PCSrcE || FlushD),
    .load_pc    (load_pc_c),
    .load_instr (load_instr_c),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .InstrD     (InstrD),
    .ValidD     (ValidD)
  );

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: transaction-level reference model plus memory responder.
module tb_ifetch;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] PCD, PCPlus4D, InstrD;
  logic        ValidD;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        MisalignF;
`endif

  ifetch_if imem ();

  ifetch #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (imem),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .InstrD    (InstrD),
    .ValidD    (ValidD)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .MisalignF (MisalignF)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: outstanding-request bookkeeping, not the RTL state machine
  logic        m_req, m_out, m_drop, m_held_v, m_go, m_park, m_vld;
  logic [31:0] m_addr, m_fa, m_next, m_held_pc, m_held_ins, m_pcd, m_pcp4, m_ins;

  // Memory responder
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  int          lat = 1;
  logic [31:0] mem_addr = '0;
  logic [31:0] resp_addr = '0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return 32'h0050_0093 + (a << 8);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("ImemReq",  32'(imem.ImemReq), 32'(m_req));
    check("ImemAddr", imem.ImemAddr, m_addr);
    check("PCD",      PCD, m_pcd);
    check("PCPlus4D", PCPlus4D, m_pcp4);
    check("InstrD",   InstrD, m_ins);
    check("ValidD",   32'(ValidD), 32'(m_vld));
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("MisalignF", 32'(MisalignF), 32'(m_park));
`endif
  endtask

  task automatic model_reset();
    m_req = 0; m_addr = RST_PC; m_out = 0; m_fa = '0; m_next = RST_PC;
    m_drop = 0; m_held_v = 0; m_held_pc = '0; m_held_ins = NOP;
    m_go = 1; m_park = 0; m_pcd = '0; m_pcp4 = '0; m_ins = NOP; m_vld = 0;
  endtask

  task automatic issue();
    m_req = 1; m_addr = m_next; m_out = 1; m_fa = m_next;
  endtask

  task automatic model_step();
    logic        acc, bad, st, fl, src, v;
    logic [31:0] t, rd;
    st = StallD; fl = FlushD; src = PCSrcE; v = imem.ImemValid; rd = imem.ImemRData;
    acc = m_out && !m_req && v;
`ifdef IFETCH_MISALIGN_TRAP_EN
    t = PCTargetE; bad = src && (PCTargetE[1:0] != 2'b00);
`else
    t = {PCTargetE[31:2], 2'b00}; bad = 1'b0;
`endif
    if (src || fl) begin
      m_vld = 0; m_ins = NOP;
    end else if (!st) begin
      if (acc && !m_drop) begin
        m_pcd = m_fa; m_pcp4 = m_fa + 32'd4; m_ins = rd; m_vld = 1;
      end else if (m_held_v) begin
        m_pcd = m_held_pc; m_pcp4 = m_held_pc + 32'd4; m_ins = m_held_ins; m_vld = 1;
      end
    end
    m_req = 0;
    if (src) begin
      m_next = t; m_held_v = 0; m_go = 0; m_park = bad;
      if (m_out && !acc) m_drop = 1;
      else begin
        m_out = 0; m_drop = 0;
        if (!bad) issue();
      end
    end else if (m_go) begin
      m_go = 0;
      if (!m_park) issue();
    end else if (acc) begin
      m_out = 0;
      if (m_drop) begin
        m_drop = 0;
        if (!m_park) issue();
      end else begin
        m_next = m_fa + 32'd4;
        if (st) begin
          m_held_v = 1; m_held_pc = m_fa; m_held_ins = rd;
        end else issue();
      end
    end else if (m_held_v && !st) begin
      m_held_v = 0;
      issue();
    end
  endtask

  // Drive this cycle's memory response and capture a newly visible request
  task automatic mem_phase();
    imem.ImemValid = 1'b0;
    imem.ImemRData = $urandom;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem.ImemValid = 1'b1;
        imem.ImemRData = mem_word(mem_addr);
        resp_addr      = mem_addr;
        mem_busy       = 1'b0;
      end else mem_cnt--;
    end
    if (m_req) begin
      mem_busy = 1'b1; mem_cnt = lat - 1; mem_addr = m_addr;
    end
  endtask

  task automatic set_in(logic st, logic fl, logic src, logic [31:0] tgt);
    StallD = st; FlushD = fl; PCSrcE = src; PCTargetE = tgt;
  endtask

  task automatic tick_end();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic step(logic st, logic fl, logic src, logic [31:0] tgt);
    mem_phase();
    set_in(st, fl, src, tgt);
    tick_end();
  endtask

  // Leaves the cycle open (response driven) when the response for addr shows up
  task automatic wait_resp(logic [31:0] addr);
    logic found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      mem_phase();
      if (imem.ImemValid && resp_addr == addr) begin
        found = 1'b1;
        break;
      end
      set_in(0, 0, 0, '0);
      tick_end();
    end
    check("resp_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_req_at(string tag, logic [31:0] addr);
    logic found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_req && m_addr == addr) begin
        found = 1'b1;
        break;
      end
      step(0, 0, 0, '0);
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
    check({tag, "_req"}, 32'(imem.ImemReq), 32'd1);
    check({tag, "_addr"}, imem.ImemAddr, addr);
  endtask

  initial begin
    set_in(0, 0, 0, '0);
    imem.ImemValid = 1'b0;
    imem.ImemRData = '0;
    model_reset();
    #2 reset = 1'b0;
    #1 check_all();
    @(posedge clk);
    #1 reset = 1'b1;

    // First fetch from reset PC with single-cycle memory
    lat = 1;
    step(0, 0, 0, '0);
    check("first_req", 32'(imem.ImemReq), 32'd1);
    check("first_addr", imem.ImemAddr, RST_PC);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    check("first_valid", 32'(ValidD), 32'd1);
    check("first_instr", InstrD, 32'h0050_0093);
    check("first_pcd", PCD, 32'h0);
    check("first_pcp4", PCPlus4D, 32'h4);
    check("next_addr", imem.ImemAddr, 32'h4);

    // Stall while the response for 8 arrives
    wait_resp(32'h8);
    set_in(1, 0, 0, '0);
    tick_end();
    check("stall_pcd", PCD, 32'h4);
    check("stall_noreq", 32'(imem.ImemReq), 32'd0);
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    check("stall3_pcd", PCD, 32'h4);
    lat = 3;
    step(0, 0, 0, '0);
    check("unstall_pcd", PCD, 32'h8);
    check("unstall_instr", InstrD, mem_word(32'h8));
    check("unstall_addr", imem.ImemAddr, 32'hC);

    // Redirect while the request to 16 is outstanding
    wait_req_at("req16", 32'h10);
    step(0, 0, 0, '0);
    step(0, 0, 1, 32'h100);
    check("redir_valid", 32'(ValidD), 32'd0);
    check("redir_instr", InstrD, NOP);
    wait_req_at("redir", 32'h100);

    // Flush together with stall
    for (int i = 0; i < 40 && !m_vld; i++) step(0, 0, 0, '0);
    step(1, 1, 0, '0);
    check("flush_valid", 32'(ValidD), 32'd0);
    check("flush_instr", InstrD, NOP);
    step(0, 0, 0, '0);

    // Reset mid-request; the late response must be ignored
    for (int i = 0; i < 40 && !m_req; i++) step(0, 0, 0, '0);
    mem_phase();
    #2 reset = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1;
    mem_phase();
    check_all();
    #1 reset = 1'b1;
    set_in(0, 0, 0, '0);
    tick_end();
    step(0, 0, 0, '0);
    wait_resp(RST_PC);
    set_in(0, 0, 0, '0);
    tick_end();
    check("rst_pcd", PCD, RST_PC);
    check("rst_instr", InstrD, mem_word(RST_PC));

    // Misaligned redirect
    step(0, 0, 1, 32'h102);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("mis_flag", 32'(MisalignF), 32'd1);
    repeat (6) step(0, 0, 0, '0);
    check("mis_noreq", 32'(imem.ImemReq), 32'd0);
    step(0, 0, 1, 32'h200);
    wait_req_at("realign", 32'h200);
    check("mis_clear", 32'(MisalignF), 32'd0);
`else
    wait_req_at("mis", 32'h100);
`endif

    // PC wrap at the top of the address space
    step(0, 0, 1, 32'hFFFF_FFFC);
    wait_resp(32'hFFFF_FFFC);
    set_in(0, 0, 0, '0);
    tick_end();
    check("wrap_pcd", PCD, 32'hFFFF_FFFC);
    check("wrap_pcp4", PCPlus4D, 32'h0);
    check("wrap_addr", imem.ImemAddr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] tgt;
      int          sel;
      lat = int'($urandom_range(1, 3));
      sel = int'($urandom_range(0, 7));
      if (sel == 0) tgt = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else if (sel == 1) tgt = $urandom & 32'h0000_0FFF;
      else tgt = $urandom & 32'h0000_FFFC;
      step(($urandom % 10) < 3, ($urandom % 20) == 0, ($urandom % 16) == 0, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
